// File: rtl/kugelblitz_pkg.sv
// kugelblitz_pkg: shared FSM encoding and default counter width for the offload arbiter
package kugelblitz_pkg;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  localparam int COUNT_WIDTH_DEFAULT = 32;
endpackage

// File: rtl/kugelblitz_axis_reg.sv
// kugelblitz_axis_reg: single-entry AXI stream pipeline register carrying a source-id sideband
module kugelblitz_axis_reg #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tlast,
  input  logic [USER_WIDTH-1:0] s_tuser,
  input  logic                  s_tid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic                  m_tid
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tid    <= 1'b0;
    end else if (load) begin
      m_tvalid <= 1'b1;
      m_tlast  <= s_tlast;
      m_tid    <= s_tid;
    end else if (m_tready) m_tvalid <= 1'b0;
  // payload is qualified by m_tvalid, so it carries no reset
  always_ff @(posedge clk)
    if (load) begin
      m_tdata <= s_tdata;
      m_tkeep <= s_tkeep;
      m_tuser <= s_tuser;
    end
endmodule

// File: rtl/kugelblitz_offload_arb.sv
// kugelblitz_offload_arb: frame-granular round-robin arbiter merging two qsfp RX streams
// into the shared offload engine, with per-port forwarded-frame counters.
module kugelblitz_offload_arb
  import kugelblitz_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int USER_WIDTH  = 1,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  s0_axis_tkeep,
  input  logic                   s0_axis_tvalid,
  output logic                   s0_axis_tready,
  input  logic                   s0_axis_tlast,
  input  logic [USER_WIDTH-1:0]  s0_axis_tuser,
  input  logic [DATA_WIDTH-1:0]  s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  s1_axis_tkeep,
  input  logic                   s1_axis_tvalid,
  output logic                   s1_axis_tready,
  input  logic                   s1_axis_tlast,
  input  logic [USER_WIDTH-1:0]  s1_axis_tuser,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [USER_WIDTH-1:0]  m_axis_tuser,
  output logic                   m_axis_tid,
  input  logic [1:0]             enable,
  output logic [COUNT_WIDTH-1:0] frame_count0,
  output logic [COUNT_WIDTH-1:0] frame_count1
);
  state_t state, state_n;
  logic grant, last_grant, grant_n, open, load, sel_last, frame_end;
  logic [1:0] req;
  assign req = {s1_axis_tvalid & enable[1], s0_axis_tvalid & enable[0]};
  // on contention the port that did not win last time gets the grant
  assign grant_n = &req ? ~last_grant : req[1];
  assign open = ~m_axis_tvalid | m_axis_tready;
  assign load = grant ? s1_axis_tvalid & s1_axis_tready : s0_axis_tvalid & s0_axis_tready;
  assign sel_last = grant ? s1_axis_tlast : s0_axis_tlast;
  assign frame_end = load & sel_last;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (|req ? ACTIVE : IDLE) : (frame_end ? IDLE : ACTIVE);
  always_comb begin
    s0_axis_tready = state == ACTIVE && !grant && open;
    s1_axis_tready = state == ACTIVE && grant && open;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      frame_count0 <= '0;
      frame_count1 <= '0;
    end else begin
      if (state == IDLE && |req) grant <= grant_n;
      if (frame_end) begin
        last_grant <= grant;
        if (grant) frame_count1 <= frame_count1 + COUNT_WIDTH'(1);
        else frame_count0 <= frame_count0 + COUNT_WIDTH'(1);
      end
    end
  kugelblitz_axis_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH),
    .USER_WIDTH(USER_WIDTH)
  ) u_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .s_tdata  (grant ? s1_axis_tdata : s0_axis_tdata),
    .s_tkeep  (grant ? s1_axis_tkeep : s0_axis_tkeep),
    .s_tlast  (sel_last),
    .s_tuser  (grant ? s1_axis_tuser : s0_axis_tuser),
    .s_tid    (grant),
    .m_tready (m_axis_tready),
    .m_tdata  (m_axis_tdata),
    .m_tkeep  (m_axis_tkeep),
    .m_tvalid (m_axis_tvalid),
    .m_tlast  (m_axis_tlast),
    .m_tuser  (m_axis_tuser),
    .m_tid    (m_axis_tid)
  );
endmodule

// File: tb/tb_kugelblitz_offload_arb.sv
// tb_kugelblitz_offload_arb: table vectors, directed corner sequences and randomized traffic
// checked against per-port frame queues and frame counts.
module tb_kugelblitz_offload_arb;
  import kugelblitz_pkg::*;
  logic clk = 0, rst = 1;
  logic [63:0] s0_axis_tdata = 0, s1_axis_tdata = 0, m_axis_tdata;
  logic [7:0] s0_axis_tkeep = 0, s1_axis_tkeep = 0, m_axis_tkeep;
  logic [1:0] s0_axis_tuser = 0, s1_axis_tuser = 0, m_axis_tuser, enable = 0;
  logic s0_axis_tvalid = 0, s0_axis_tready, s0_axis_tlast = 0;
  logic s1_axis_tvalid = 0, s1_axis_tready, s1_axis_tlast = 0;
  logic m_axis_tvalid, m_axis_tready = 1, m_axis_tlast, m_axis_tid;
  logic [31:0] frame_count0, frame_count1;

  kugelblitz_offload_arb #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .USER_WIDTH(2), .COUNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tready(s0_axis_tready), .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tready(s1_axis_tready), .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tid(m_axis_tid), .enable(enable),
    .frame_count0(frame_count0), .frame_count1(frame_count1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [1:0]  user;
    logic        last;
  } beat_t;
  typedef struct {
    logic [1:0] en;
    logic       v0, v1, exp_v, exp_tid;
  } vec_t;

  beat_t q0[$], q1[$], exp0[$], exp1[$], sent[$];
  int flog[$];
  int errs = 0, checks = 0, n0 = 0, n1 = 0;
  logic gaps = 0, rand_ready = 0, in_frame = 0, cur_tid = 0;
  logic hold_chk = 0, hold_last, hold_tid;
  logic [63:0] hold_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic score();
    beat_t b;
    if (in_frame) chk("no_interleave", 64'(m_axis_tid), 64'(cur_tid));
    if ((m_axis_tid ? exp1.size() : exp0.size()) == 0) begin
      checks++;
      errs++;
      $display("FAIL extra_beat tid=%0d actual=beat required=none at %0t", m_axis_tid, $time);
    end else begin
      b = m_axis_tid ? exp1.pop_front() : exp0.pop_front();
      chk("beat_data", m_axis_tdata, b.data);
      chk("beat_keep", 64'(m_axis_tkeep), 64'(b.keep));
      chk("beat_user", 64'(m_axis_tuser), 64'(b.user));
      chk("beat_last", 64'(m_axis_tlast), 64'(b.last));
    end
    in_frame = !m_axis_tlast;
    cur_tid = m_axis_tid;
    if (m_axis_tlast) flog.push_back(int'(m_axis_tid));
  endtask

  // samples pre-edge handshakes; a stalled output beat must not change
  always @(posedge clk) begin
    if (!rst) begin
      if (hold_chk) begin
        chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
        chk("hold_data", m_axis_tdata, hold_data);
        chk("hold_last", 64'(m_axis_tlast), 64'(hold_last));
        chk("hold_tid", 64'(m_axis_tid), 64'(hold_tid));
      end
      if (s0_axis_tvalid && s0_axis_tready) void'(q0.pop_front());
      if (s1_axis_tvalid && s1_axis_tready) void'(q1.pop_front());
      if (m_axis_tvalid && m_axis_tready) score();
    end
    hold_chk = !rst && m_axis_tvalid && !m_axis_tready;
    hold_data = m_axis_tdata;
    hold_last = m_axis_tlast;
    hold_tid = m_axis_tid;
  end

  task automatic drive();
    s0_axis_tvalid = q0.size() > 0 && (!gaps || $urandom_range(3) != 0);
    s1_axis_tvalid = q1.size() > 0 && (!gaps || $urandom_range(3) != 0);
    if (q0.size() > 0) begin
      s0_axis_tdata = q0[0].data; s0_axis_tkeep = q0[0].keep;
      s0_axis_tuser = q0[0].user; s0_axis_tlast = q0[0].last;
    end
    if (q1.size() > 0) begin
      s1_axis_tdata = q1[0].data; s1_axis_tkeep = q1[0].keep;
      s1_axis_tuser = q1[0].user; s1_axis_tlast = q1[0].last;
    end
    if (rand_ready) m_axis_tready = 1'($urandom_range(1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic send_frame(input int port, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = 8'($urandom);
      b.user = 2'($urandom);
      b.last = (i == len - 1);
      if (port == 0) begin q0.push_back(b); exp0.push_back(b); end
      else begin q1.push_back(b); exp1.push_back(b); end
    end
    if (port == 0) n0++; else n1++;
  endtask

  task automatic do_reset();
    rst = 1;
    q0.delete(); q1.delete(); exp0.delete(); exp1.delete(); flog.delete();
    in_frame = 0; n0 = 0; n1 = 0;
    drive();
    step();
    step();
    rst = 0;
    drive();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp0.size() > 0 || exp1.size() > 0 || m_axis_tvalid) && n < 3000) begin
      step();
      n++;
    end
    chk({name, "_drain_timeout"}, 64'(n < 3000), 64'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!m_axis_tvalid && n < 50) begin step(); n++; end
    chk({name, "_valid_timeout"}, 64'(n < 50), 64'd1);
  endtask

  initial begin
    automatic vec_t vecs[9];
    automatic int ev[7] = '{0, 0, 1, 1, 0, 1, 1};
    automatic int et[7] = '{0, 0, 0, 0, 0, 1, 1};
    automatic logic tv[7], ttid[7];
    automatic logic [3:0] seq = 4'b1001;
    automatic logic any;
    automatic int lat;
    vecs[0] = '{2'b00, 1, 1, 0, 0};
    vecs[1] = '{2'b11, 0, 0, 0, 0};
    vecs[2] = '{2'b11, 1, 0, 1, 0};
    vecs[3] = '{2'b11, 0, 1, 1, 1};
    vecs[4] = '{2'b11, 1, 1, 1, 0};
    vecs[5] = '{2'b01, 0, 1, 0, 0};
    vecs[6] = '{2'b10, 1, 1, 1, 1};
    vecs[7] = '{2'b01, 1, 1, 1, 0};
    vecs[8] = '{2'b10, 1, 0, 0, 0};

    #12;
    chk("rst_tvalid", 64'(m_axis_tvalid), 0);
    chk("rst_tlast", 64'(m_axis_tlast), 0);
    chk("rst_tid", 64'(m_axis_tid), 0);
    chk("rst_cnt0", 64'(frame_count0), 0);
    chk("rst_cnt1", 64'(frame_count1), 0);
    chk("rst_ready", 64'({s1_axis_tready, s0_axis_tready}), 0);
    chk("rst_state", 64'(dut.state == IDLE), 1);
    chk("rst_grant", 64'(dut.grant), 0);
    chk("rst_last_grant", 64'(dut.last_grant), 1);

    foreach (vecs[i]) begin
      do_reset();
      enable = vecs[i].en;
      if (vecs[i].v0) send_frame(0, 1);
      if (vecs[i].v1) send_frame(1, 1);
      drive();
      step();
      step();
      chk($sformatf("vec%0d_valid", i), 64'(m_axis_tvalid), 64'(vecs[i].exp_v));
      if (vecs[i].exp_v) chk($sformatf("vec%0d_tid", i), 64'(m_axis_tid), 64'(vecs[i].exp_tid));
      else chk($sformatf("vec%0d_ready", i), 64'({s1_axis_tready, s0_axis_tready}), 0);
    end

    do_reset();
    enable = 2'b11;
    send_frame(0, 3);
    drive();
    lat = 0;
    while (!m_axis_tvalid && lat < 20) begin step(); lat++; end
    chk("latency", 64'(lat), 2);
    drain("single");
    chk("single_cnt0", 64'(frame_count0), 1);
    chk("single_frames", 64'(flog.size()), 1);

    do_reset();
    enable = 2'b11;
    send_frame(0, 2);
    send_frame(1, 2);
    drive();
    for (int k = 1; k < 7; k++) begin
      step();
      tv[k] = m_axis_tvalid;
      ttid[k] = m_axis_tid;
    end
    for (int k = 2; k < 7; k++) begin
      chk($sformatf("both_valid%0d", k), 64'(tv[k]), 64'(ev[k]));
      if (ev[k] != 0) chk($sformatf("both_tid%0d", k), 64'(ttid[k]), 64'(et[k]));
    end
    drain("both");
    chk("both_cnt0", 64'(frame_count0), 1);
    chk("both_cnt1", 64'(frame_count1), 1);

    do_reset();
    enable = 2'b11;
    send_frame(0, 4);
    sent = exp0;
    drive();
    wait_valid("stall");
    for (int i = 3; i >= 0; i--) begin
      m_axis_tready = seq[i];
      step();
    end
    chk("stall_valid", 64'(m_axis_tvalid), 1);
    chk("stall_beat", m_axis_tdata, sent[2].data);
    m_axis_tready = 1;
    drain("stall");
    chk("stall_cnt0", 64'(frame_count0), 1);

    do_reset();
    enable = 2'b01;
    send_frame(1, 2);
    drive();
    any = 0;
    repeat (8) begin step(); any = any | s1_axis_tready | m_axis_tvalid; end
    chk("gate_ready", 64'(any), 0);
    chk("gate_cnt1", 64'(frame_count1), 0);
    enable = 2'b11;
    drain("gate");
    chk("gate_cnt1_after", 64'(frame_count1), 1);

    do_reset();
    enable = 2'b11;
    force dut.frame_count0 = 32'hFFFF_FFFF;
    step();
    release dut.frame_count0;
    chk("preload", 64'(frame_count0), 64'hFFFF_FFFF);
    send_frame(0, 1);
    drive();
    drain("wrap");
    chk("wrap_cnt0", 64'(frame_count0), 0);

    do_reset();
    enable = 2'b11;
    send_frame(1, 1);
    drive();
    drain("pre_rst");
    chk("pre_rst_cnt1", 64'(frame_count1), 1);
    send_frame(0, 4);
    drive();
    wait_valid("midrst");
    step();
    chk("midrst_busy", 64'(m_axis_tvalid), 1);
    rst = 1;
    #1;
    chk("midrst_valid", 64'(m_axis_tvalid), 0);
    chk("midrst_state", 64'(dut.state == IDLE), 1);
    chk("midrst_cnts", 64'({frame_count1, frame_count0}), 0);
    chk("midrst_ready", 64'(s0_axis_tready), 0);
    do_reset();
    enable = 2'b11;
    send_frame(0, 2);
    drive();
    drain("post_rst");
    chk("post_rst_cnt0", 64'(frame_count0), 1);

    do_reset();
    enable = 2'b11;
    gaps = 1;
    rand_ready = 1;
    repeat (40) send_frame(int'($urandom_range(1)), int'($urandom_range(4, 1)));
    drive();
    drain("rand");
    chk("rand_cnt0", 64'(frame_count0), 64'(n0));
    chk("rand_cnt1", 64'(frame_count1), 64'(n1));

    gaps = 0;
    do_reset();
    enable = 2'b11;
    for (int i = 0; i < 6; i++) begin
      send_frame(0, int'($urandom_range(4, 1)));
      send_frame(1, int'($urandom_range(4, 1)));
    end
    drive();
    drain("rr");
    chk("rr_frames", 64'(flog.size()), 12);
    foreach (flog[i]) chk($sformatf("rr_order%0d", i), 64'(flog[i]), 64'(i % 2));
    chk("rr_cnts", 64'({frame_count1, frame_count0}), {32'd6, 32'd6});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
